decoder_input_stage: RTL



---
 rtl/decoder_input_stage_if.sv | 18 +
 rtl/decoder_input_stage.sv | 98 +++++++++
 2 files changed

// File: rtl/decoder_input_stage_if.sv
// Valid/ready handshake between the input stage (master) and the 7-bit decoder core (slave).
interface decoder_input_stage_if;
    logic [6:0] code_out;
    logic       code_valid;
    logic       code_ready;

    modport master (
        output code_out,
        output code_valid,
        input  code_ready
    );

    modport slave (
        input  code_out,
        input  code_valid,
        output code_ready
    );
endinterface

// File: rtl/decoder_input_stage.sv
// Pad-word front end: two-flop synchroniser, debounce, one-shot commit of each new stable
// code and a one-entry output register with a saturating count of overwritten codes.
module decoder_input_stage #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [6:0]           raw_in,
    decoder_input_stage_if.master dec,
    output logic [6:0]           last_code,
    output logic [CNT_W-1:0]     drop_count
);

    localparam int CNT_BW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_BW-1:0] CNT_MAX = CNT_BW'(DEBOUNCE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } out_state_t;

    logic [6:0]        sync1;
    logic [6:0]        sync2;
    logic [6:0]        cand;
    logic [CNT_BW-1:0] cnt;
    logic              stable;
    logic              commit;

    out_state_t        state;
    out_state_t        state_nxt;
    logic [6:0]        code_q;
    logic [6:0]        code_nxt;
    logic [CNT_W-1:0]  drop_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Synchroniser and debounce window
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // A word that has held for DEBOUNCE+1 samples commits once, unless it repeats the last code
    assign stable = (cnt == CNT_MAX);
    assign commit = stable && (sync2 == cand) && (cand != last_code);

    // Output register: a commit always wins; an unaccepted code it replaces counts as a drop
    always_comb begin
        state_nxt = state;
        code_nxt  = code_q;
        drop_nxt  = drop_count;
        if (commit) begin
            state_nxt = HOLD;
            code_nxt  = cand;
            if (state == HOLD && !dec.code_ready) begin
                drop_nxt = sat_inc(drop_count);
            end
        end else if (state == HOLD && dec.code_ready) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            code_q     <= '0;
            drop_count <= '0;
            last_code  <= '0;
        end else begin
            state      <= state_nxt;
            code_q     <= code_nxt;
            drop_count <= drop_nxt;
            if (commit) begin
                last_code <= cand;
            end
        end
    end

    assign dec.code_out   = code_q;
    assign dec.code_valid = (state == HOLD);

endmodule
